// File: rtl/hmi_pkg.sv
// Shared definitions for the HMI command link: byte constants, the "val="
// keyword and the frame state encoding used by both sender and receiver.
package hmi_pkg;

    localparam logic [7:0]  HMI_TERM    = 8'hFF;
    localparam logic [7:0]  HMI_DOT     = ".";
    localparam logic [7:0]  HMI_EQ      = "=";
    localparam logic [7:0]  HMI_ASCII_0 = "0";
    localparam logic [7:0]  HMI_ASCII_9 = "9";
    localparam logic [7:0]  HMI_ASCII_A = "a";
    localparam logic [7:0]  HMI_ASCII_Z = "z";
    localparam logic [31:0] HMI_KEY     = "val=";

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_KEY,
        ST_VAL,
        ST_TERM,
        ST_SYNC
    } hmi_state_e;

    // Character idx of the keyword, idx 0 being the leading 'v'.
    function automatic logic [7:0] key_char(input logic [1:0] idx);
        logic [31:0] shifted;
        shifted = HMI_KEY << {idx, 3'b000};
        return shifted[31:24];
    endfunction

endpackage

// File: rtl/hmi_cmd_rx.sv
// Receive-side decoder for "<letter><id>.val=<digits> FF FF FF" frames:
// checks syntax, accumulates the decimal fields and pulses the result.
module hmi_cmd_rx
    import hmi_pkg::*;
#(
    parameter int TIMEOUT_CYC = 5000,
    parameter int MAX_DIGITS  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [7:0]  obj_type,
    output logic [6:0]  obj_id,
    output logic [16:0] obj_value,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);

    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] DIG_MAX    = DW'(MAX_DIGITS);
    localparam logic [DW-1:0] DIG_ID_MAX = DW'(2);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYC);

    hmi_state_e     state, state_nxt;
    logic [7:0]     type_q, type_nxt;
    logic [6:0]     id_q, id_nxt;
    logic [16:0]    val_q, val_nxt;
    logic [DW-1:0]  dig_cnt, dig_nxt;
    logic [1:0]     key_idx, key_nxt;
    logic [1:0]     ff_cnt, ff_nxt;
    logic [TW-1:0]  tmo_cnt, tmo_nxt;
    logic           done, err_byte, tmo_hit;

    logic       is_digit, is_letter, is_term;
    logic [3:0] digit;

    assign is_digit  = (rx_data >= HMI_ASCII_0) && (rx_data <= HMI_ASCII_9);
    assign is_letter = (rx_data >= HMI_ASCII_A) && (rx_data <= HMI_ASCII_Z);
    assign is_term   = (rx_data == HMI_TERM);
    assign digit     = 4'(rx_data - HMI_ASCII_0);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        type_nxt  = type_q;
        id_nxt    = id_q;
        val_nxt   = val_q;
        dig_nxt   = dig_cnt;
        key_nxt   = key_idx;
        ff_nxt    = ff_cnt;
        tmo_nxt   = tmo_cnt;
        done      = 1'b0;
        err_byte  = 1'b0;
        tmo_hit   = 1'b0;

        if (rx_valid) begin
            tmo_nxt = '0;
            case (state)
                ST_IDLE: begin
                    if (is_letter) begin
                        type_nxt  = rx_data;
                        id_nxt    = '0;
                        val_nxt   = '0;
                        dig_nxt   = '0;
                        state_nxt = ST_ID;
                    end else if (!is_term) begin
                        err_byte = 1'b1;
                    end
                end
                ST_ID: begin
                    if (is_digit && dig_cnt != DIG_ID_MAX) begin
                        id_nxt  = (id_q << 3) + (id_q << 1) + {3'b000, digit};
                        dig_nxt = dig_cnt + DW'(1);
                    end else if (rx_data == HMI_DOT && dig_cnt != '0) begin
                        key_nxt   = '0;
                        state_nxt = ST_KEY;
                    end else begin
                        err_byte = 1'b1;
                    end
                end
                ST_KEY: begin
                    if (rx_data != key_char(key_idx)) begin
                        err_byte = 1'b1;
                    end else if (key_idx == 2'd3) begin
                        dig_nxt   = '0;
                        state_nxt = ST_VAL;
                    end else begin
                        key_nxt = key_idx + 2'd1;
                    end
                end
                ST_VAL: begin
                    if (is_digit && dig_cnt != DIG_MAX) begin
                        // x*10 as (x<<3)+(x<<1); at most 5 digits fits 17 bits
                        val_nxt = (val_q << 3) + (val_q << 1) + {13'b0, digit};
                        dig_nxt = dig_cnt + DW'(1);
                    end else if (is_term && dig_cnt != '0) begin
                        ff_nxt    = 2'd1;
                        state_nxt = ST_TERM;
                    end else begin
                        err_byte = 1'b1;
                    end
                end
                ST_TERM: begin
                    if (!is_term) begin
                        err_byte = 1'b1;
                    end else if (ff_cnt == 2'd2) begin
                        ff_nxt    = '0;
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ff_nxt = ff_cnt + 2'd1;
                    end
                end
                ST_SYNC: begin
                    if (!is_term) begin
                        ff_nxt = '0;
                    end else if (ff_cnt == 2'd2) begin
                        ff_nxt    = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        ff_nxt = ff_cnt + 2'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase

            // An offending FF already counts toward the resync sequence.
            if (err_byte) begin
                state_nxt = ST_SYNC;
                ff_nxt    = is_term ? 2'd1 : 2'd0;
            end
        end else if (state inside {ST_ID, ST_KEY, ST_VAL, ST_TERM}) begin
            if (tmo_cnt == TMO_MAX) begin
                tmo_hit   = 1'b1;
                tmo_nxt   = '0;
                ff_nxt    = '0;
                state_nxt = ST_IDLE;
            end else begin
                tmo_nxt = tmo_cnt + TW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            type_q      <= '0;
            id_q        <= '0;
            val_q       <= '0;
            dig_cnt     <= '0;
            key_idx     <= '0;
            ff_cnt      <= '0;
            tmo_cnt     <= '0;
            obj_type    <= '0;
            obj_id      <= '0;
            obj_value   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            type_q      <= type_nxt;
            id_q        <= id_nxt;
            val_q       <= val_nxt;
            dig_cnt     <= dig_nxt;
            key_idx     <= key_nxt;
            ff_cnt      <= ff_nxt;
            tmo_cnt     <= tmo_nxt;
            frame_valid <= done;
            frame_err   <= err_byte | tmo_hit;
            busy        <= (state_nxt != ST_IDLE);
            if (done) begin
                obj_type  <= type_q;
                obj_id    <= id_q;
                obj_value <= val_q;
            end
        end
    end

endmodule

// File: tb/tb_hmi_cmd_rx.sv
// Directed bench for hmi_cmd_rx: drives byte strings, checks decoded fields,
// error/valid pulses, resync, timeout and mid-frame reset.
module tb_hmi_cmd_rx;

    localparam int TMO = 5000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [7:0]  obj_type;
    logic [6:0]  obj_id;
    logic [16:0] obj_value;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int vcnt = 0;
    int ecnt = 0;
    int both = 0;
    int v0, e0;

    hmi_cmd_rx #(.TIMEOUT_CYC(TMO), .MAX_DIGITS(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .obj_type   (obj_type),
        .obj_id     (obj_id),
        .obj_value  (obj_value),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters; sampling at posedge sees the value held over the prior cycle.
    always @(posedge clk) begin
        if (frame_valid) vcnt++;
        if (frame_err) ecnt++;
        if (frame_valid && frame_err) both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Starts and ends on a negedge; the byte is sampled at the posedge between.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_term(input int gap);
        for (int i = 0; i < 3; i++) begin
            send(8'hFF);
            if (i < 2) repeat (gap) @(negedge clk);
        end
    endtask

    task automatic check_obj(input string tag, input logic [7:0] t, input int id, input int val);
        check({tag, "_type"}, 32'(obj_type), 32'(t));
        check({tag, "_id"}, 32'(obj_id), 32'(id));
        check({tag, "_value"}, 32'(obj_value), 32'(val));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(frame_valid), 0);
        check("rst_err", 32'(frame_err), 0);
        check("rst_busy", 32'(busy), 0);
        check_obj("rst", 8'h00, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Stray FF in IDLE is ignored
        send(8'hFF);
        check("stray_ff_busy", 32'(busy), 0);
        check("stray_ff_err", 32'(frame_err), 0);

        // One byte per 10 cycles
        v0 = vcnt; e0 = ecnt;
        send_str("n2.val=01234", 9);
        send_term(9);
        check("f1_valid", 32'(frame_valid), 1);
        check_obj("f1", 8'h6E, 2, 1234);
        @(negedge clk);
        check("f1_pulse_end", 32'(frame_valid), 0);
        check("f1_busy", 32'(busy), 0);
        @(negedge clk);
        check("f1_vcnt", 32'(vcnt - v0), 1);
        check("f1_ecnt", 32'(ecnt - e0), 0);

        // Two frames back-to-back every cycle
        v0 = vcnt;
        send_str("h0.val=1", 0);
        send_term(0);
        check("f2_valid", 32'(frame_valid), 1);
        check_obj("f2", 8'h68, 0, 1);
        send_str("n7.val=99999", 0);
        send_term(0);
        check("f3_valid", 32'(frame_valid), 1);
        check_obj("f3", 8'h6E, 7, 99999);
        @(negedge clk);
        check("f23_vcnt", 32'(vcnt - v0), 2);

        // Keyword mismatch, then resync and a good frame
        v0 = vcnt; e0 = ecnt;
        send_str("n3.v", 0);
        check("vxl_no_err_early", 32'(frame_err), 0);
        send("x");
        check("vxl_err", 32'(frame_err), 1);
        check("vxl_busy_sync", 32'(busy), 1);
        send_str("l=5", 0);
        send_term(0);
        check("vxl_resync_busy", 32'(busy), 0);
        check("vxl_no_valid", 32'(frame_valid), 0);
        check_obj("vxl_hold", 8'h6E, 7, 99999);
        @(negedge clk);
        check("vxl_vcnt", 32'(vcnt - v0), 0);
        check("vxl_ecnt", 32'(ecnt - e0), 1);
        send_str("n4.val=7", 0);
        send_term(0);
        check("f4_valid", 32'(frame_valid), 1);
        check_obj("f4", 8'h6E, 4, 7);

        // Too many value digits
        e0 = ecnt;
        send_str("n5.val=12345", 0);
        check("dig5_no_err", 32'(frame_err), 0);
        send("6");
        check("dig6_err", 32'(frame_err), 1);
        send_term(0);
        check("dig6_resync_busy", 32'(busy), 0);
        check_obj("dig6_hold", 8'h6E, 4, 7);

        // Wrong key name: error on the 't' after the dot
        e0 = ecnt;
        send_str("t13.", 0);
        check("txt_no_err_dot", 32'(frame_err), 0);
        send("t");
        check("txt_err", 32'(frame_err), 1);
        send_str("xt=\"on\"", 0);
        send_term(0);
        check("txt_busy", 32'(busy), 0);
        @(negedge clk);
        check("txt_ecnt", 32'(ecnt - e0), 1);

        // Timeout after TMO idle cycles inside a frame
        v0 = vcnt; e0 = ecnt;
        send_str("n6.val=4", 0);
        repeat (TMO) @(negedge clk);
        check("tmo_pre_err", 32'(frame_err), 0);
        check("tmo_pre_busy", 32'(busy), 1);
        @(negedge clk);
        check("tmo_err", 32'(frame_err), 1);
        check("tmo_idle", 32'(busy), 0);
        @(negedge clk);
        check("tmo_err_pulse_end", 32'(frame_err), 0);
        check_obj("tmo_hold", 8'h6E, 4, 7);

        // Byte arriving exactly at the terminal-count cycle wins
        e0 = ecnt;
        send_str("n6.val=4", 0);
        repeat (TMO) @(negedge clk);
        send(8'hFF);
        check("tc_byte_no_err", 32'(frame_err), 0);
        check("tc_byte_busy", 32'(busy), 1);
        send(8'hFF);
        send(8'hFF);
        check("tc_valid", 32'(frame_valid), 1);
        check_obj("tc", 8'h6E, 6, 4);
        @(negedge clk);
        check("tc_ecnt", 32'(ecnt - e0), 0);

        // Reset mid-frame
        v0 = vcnt; e0 = ecnt;
        send_str("n2.va", 0);
        #2 rst = 1'b1;
        #1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_valid", 32'(frame_valid), 0);
        check("mrst_err", 32'(frame_err), 0);
        check_obj("mrst", 8'h00, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_vcnt", 32'(vcnt - v0), 0);
        check("mrst_ecnt", 32'(ecnt - e0), 0);
        send_str("n2.val=01234", 0);
        send_term(0);
        check("post_rst_valid", 32'(frame_valid), 1);
        check_obj("post_rst", 8'h6E, 2, 1234);

        @(negedge clk);
        check("never_both", 32'(both), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
